// File: rtl/hazard_fwd_ctl.sv
// hazard_fwd_ctl
//   Decode-stage hazard and forwarding controller. A two-entry shadow
//   pipeline (EX, MEM) records the in-flight register writers. The operands
//   of the instruction in decode are checked against that pipeline to choose
//   bypass selects or to insert a bubble. Operands are resolved in decode
//   because branches, jr and jalr resolve there. Producers that are already
//   at WB distance are served by regfile write-through.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   id_valid        decode slot holds a real instruction
//   id_rs/id_rt     decode source registers
//   id_uses_rs/rt   instruction reads Rs / Rt
//   id_dest         resolved destination register
//   id_regwrite     instruction writes id_dest
//   id_is_load      result available only at WB
//   id_is_link      jal/jalr, result is the link value
//   IDEX_Clear      insert a bubble into ID/EX
//   pc_stall_en     hold PC and IF/ID
//   ForwardC        Rs <- link value of the MEM-stage jal/jalr
//   ForwardE        10: Rs, 01: Rt <- MEM-stage ALU result
//   ForwardF        10: Rs, 01: Rt <- EX-stage ALU result
//   stall_count     saturating count of stall cycles
module hazard_fwd_ctl #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dest,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_is_link,
  output logic              IDEX_Clear,
  output logic              pc_stall_en,
  output logic              ForwardC,
  output logic [1:0]        ForwardE,
  output logic [1:0]        ForwardF,
  output logic [PERF_W-1:0] stall_count
);

  // Shadow pipeline. Only the valid bits are reset. The other fields are
  // ignored while their valid bit is low.
  logic              ex_v_q, ex_v_d, mem_v_q, mem_v_d;
  logic [4:0]        ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
  logic              ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d;
  logic              ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d;
  logic              ex_lk_q, ex_lk_d, mem_lk_q, mem_lk_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;

  logic nrs, nrt;
  logic ex_rs, mem_rs, ex_rt, mem_rt;
  logic stall_rs, stall_rt, same_reg, stall;
  logic fwd_c, fwd_e_rs, fwd_e_rt, fwd_f_rs, fwd_f_rt;

  function automatic logic hit(input logic v, input logic rw,
                               input logic [4:0] dest, input logic [4:0] r);
    return v & rw & (dest == r) & (r != 5'd0);
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    nrs      = id_valid & id_uses_rs;
    nrt      = id_valid & id_uses_rt;
    ex_rs    = hit(ex_v_q,  ex_rw_q,  ex_dest_q,  id_rs);
    mem_rs   = hit(mem_v_q, mem_rw_q, mem_dest_q, id_rs);
    ex_rt    = hit(ex_v_q,  ex_rw_q,  ex_dest_q,  id_rt);
    mem_rt   = hit(mem_v_q, mem_rw_q, mem_dest_q, id_rt);
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    fwd_c    = 1'b0;
    fwd_e_rs = 1'b0;
    fwd_e_rt = 1'b0;
    fwd_f_rs = 1'b0;
    fwd_f_rt = 1'b0;

    // The youngest producer wins, so the EX hit is checked before the MEM hit.
    if (nrs) begin
      if (ex_rs) begin
        if (ex_ld_q | ex_lk_q) stall_rs = 1'b1;
        else                   fwd_f_rs = 1'b1;
      end else if (mem_rs) begin
        if (mem_ld_q)      stall_rs = 1'b1;
        else if (mem_lk_q) fwd_c    = 1'b1;
        else               fwd_e_rs = 1'b1;
      end
    end

    // There is no link bypass path on Rt, so a MEM-stage link producer stalls.
    if (nrt) begin
      if (ex_rt) begin
        if (ex_ld_q | ex_lk_q) stall_rt = 1'b1;
        else                   fwd_f_rt = 1'b1;
      end else if (mem_rt) begin
        if (mem_ld_q | mem_lk_q) stall_rt = 1'b1;
        else                     fwd_e_rt = 1'b1;
      end
    end

    // A 2-bit select can steer only one operand. When Rs and Rt name the same
    // producer, the instruction waits until the value reaches the regfile.
    same_reg = nrs & nrt & (id_rs == id_rt) & (ex_rs | mem_rs);
    stall    = stall_rs | stall_rt | same_reg;

    IDEX_Clear  = stall;
    pc_stall_en = stall;
    ForwardC    = fwd_c & ~stall;
    ForwardE    = stall ? 2'b00 : {fwd_e_rs, fwd_e_rt};
    ForwardF    = stall ? 2'b00 : {fwd_f_rs, fwd_f_rt};
    stall_count = cnt_q;

    // A stalled decode sends a bubble into EX.
    mem_v_d    = ex_v_q;
    mem_dest_d = ex_dest_q;
    mem_rw_d   = ex_rw_q;
    mem_ld_d   = ex_ld_q;
    mem_lk_d   = ex_lk_q;
    ex_v_d     = id_valid & ~stall;
    ex_dest_d  = id_dest;
    ex_rw_d    = id_regwrite;
    ex_ld_d    = id_is_load;
    ex_lk_d    = id_is_link;
    cnt_d      = stall ? sat_inc(cnt_q) : cnt_q;
  end

  // ---- shadow pipeline control / counter ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_v_q  <= ex_v_d;
      mem_v_q <= mem_v_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- shadow pipeline data fields ----
  always_ff @(posedge clk) begin
    ex_dest_q  <= ex_dest_d;
    ex_rw_q    <= ex_rw_d;
    ex_ld_q    <= ex_ld_d;
    ex_lk_q    <= ex_lk_d;
    mem_dest_q <= mem_dest_d;
    mem_rw_q   <= mem_rw_d;
    mem_ld_q   <= mem_ld_d;
    mem_lk_q   <= mem_lk_d;
  end

endmodule

// File: tb/tb_hazard_fwd_ctl.sv
module tb_hazard_fwd_ctl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       ld;
    logic       lk;
  } id_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
  logic        id_regwrite = 1'b0, id_is_load = 1'b0, id_is_link = 1'b0;
  logic        IDEX_Clear, pc_stall_en, ForwardC;
  logic [1:0]  ForwardE, ForwardF;
  logic [15:0] stall_count;
  logic [6:0]  obs;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stalls = '0;
  logic [22:0] sb_q[$];

  assign obs = {IDEX_Clear, pc_stall_en, ForwardC, ForwardE, ForwardF};

  always #5 clk = ~clk;

  hazard_fwd_ctl #(.PERF_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_link(id_is_link),
    .IDEX_Clear(IDEX_Clear), .pc_stall_en(pc_stall_en), .ForwardC(ForwardC),
    .ForwardE(ForwardE), .ForwardF(ForwardF), .stall_count(stall_count)
  );

  function automatic id_t mk(int v, int rs, int rt, int urs, int urt,
                             int d, int rw, int ld, int lk);
    id_t x;
    x.v = v[0]; x.rs = rs[4:0]; x.rt = rt[4:0]; x.urs = urs[0]; x.urt = urt[0];
    x.dest = d[4:0]; x.rw = rw[0]; x.ld = ld[0]; x.lk = lk[0];
    return x;
  endfunction

  function automatic id_t alu(int rs, int rt, int d); return mk(1, rs, rt, 1, 1, d, 1, 0, 0); endfunction
  function automatic id_t ldw(int rs, int d);         return mk(1, rs, 0, 1, 0, d, 1, 1, 0); endfunction
  function automatic id_t rd2(int rs, int rt);        return mk(1, rs, rt, 1, 1, 0, 0, 0, 0); endfunction
  function automatic id_t rd1(int rs);                return mk(1, rs, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic id_t jal();                      return mk(1, 0, 0, 0, 0, 31, 1, 0, 1); endfunction
  function automatic id_t nop();                      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic id_t bub();                      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

  task automatic drive(input id_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_dest = x.dest; id_regwrite = x.rw; id_is_load = x.ld; id_is_link = x.lk;
  endtask

  // expected vector order: {IDEX_Clear, pc_stall_en, ForwardC, ForwardE[1:0], ForwardF[1:0]}

  task automatic test_reset();
    logic [22:0] got;
    drive(alu(3, 3, 3));
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back({7'b0, 16'd0});
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL reset_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL reset_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
    end
    rst = 1'b1;
    exp_stalls = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_basic();
    id_t s[10]; logic [6:0] e[10]; logic [22:0] got;
    s = '{alu(1, 2, 3), alu(3, 4, 8), alu(1, 2, 3), alu(4, 3, 9), rd1(3),
          rd2(0, 9), alu(1, 2, 10), mk(0, 10, 10, 1, 1, 0, 0, 0, 0), alu(10, 0, 11), bub()};
    e = '{7'b0000000, 7'b0000010, 7'b0000000, 7'b0000001, 7'b0001000,
          7'b0000100, 7'b0000000, 7'b0000000, 7'b0001000, 7'b0000000};
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL fwd_basic_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL fwd_basic_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall();
    id_t s[10]; logic [6:0] e[10]; logic [22:0] got;
    s = '{bub(), bub(), ldw(1, 5), rd2(5, 0), rd2(5, 0), rd2(5, 0),
          ldw(1, 6), nop(), rd1(6), rd1(6)};
    e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1100000, 7'b1100000, 7'b0000000,
          7'b0000000, 7'b0000000, 7'b1100000, 7'b0000000};
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL load_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL load_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_link();
    id_t s[12]; logic [6:0] e[12]; logic [22:0] got;
    s = '{bub(), bub(), jal(), nop(), rd1(31), jal(), nop(), rd2(29, 31),
          rd2(29, 31), jal(), rd1(31), rd1(31)};
    e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0010000, 7'b0000000,
          7'b0000000, 7'b1100000, 7'b0000000, 7'b0000000, 7'b1100000, 7'b0010000};
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL link_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL link_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    id_t s[9]; logic [6:0] e[9]; logic [22:0] got;
    s = '{bub(), bub(), alu(1, 2, 7), alu(1, 2, 7), rd1(7), rd2(0, 7),
          alu(1, 2, 12), alu(1, 2, 12), rd2(0, 12)};
    e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000010, 7'b0000100,
          7'b0000000, 7'b0000000, 7'b0000001};
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL prio_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL prio_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_reg();
    id_t s[14]; logic [6:0] e[14]; logic [22:0] got;
    s = '{bub(), bub(), alu(1, 3, 2), alu(2, 2, 9), alu(2, 2, 9), alu(2, 2, 9),
          alu(1, 3, 4), nop(), alu(4, 4, 9), alu(4, 4, 9),
          alu(1, 3, 0), alu(0, 0, 5), ldw(1, 0), rd2(0, 0)};
    e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1100000, 7'b1100000, 7'b0000000,
          7'b0000000, 7'b0000000, 7'b1100000, 7'b0000000,
          7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    for (int i = 0; i < 14; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL same_reg_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL same_reg_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    id_t s[4]; logic [6:0] e[4]; logic [22:0] got;
    s = '{bub(), bub(), ldw(1, 5), rd2(5, 0)};
    e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1100000};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      sb_q.push_back({e[i], exp_stalls});
      exp_stalls = exp_stalls + 16'(e[i][5]);
      @(negedge clk);
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL rst_stall_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL rst_stall_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    // The load is still in EX and the stall is active. Reset asynchronously.
    rst = 1'b0;
    exp_stalls = '0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({7'b0, 16'd0});
      if (i == 0) #1;
      else if (i == 1) begin @(posedge clk); #1; end
      else begin
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
      end
      got = sb_q.pop_front();
      n_assert++;
      if (obs !== got[22:16]) begin n_fail++; $display("FAIL rst_mid_outs[%0d] got=%b want=%b", i, obs, got[22:16]); end
      n_assert++;
      if (stall_count !== got[15:0]) begin n_fail++; $display("FAIL rst_mid_count[%0d] got=%0d want=%0d", i, stall_count, got[15:0]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_fwd_basic();
    test_load_stall();
    test_link();
    test_priority();
    test_same_reg();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
